// File: rtl/cam_config_seq_if.sv
// Write-request channel between the config sequencer (master) and the SCCB master (slave).
interface cam_config_seq_if;
  logic       sccb_valid;
  logic       sccb_ready;
  logic [7:0] sccb_addr;
  logic [7:0] sccb_data;
  logic       sccb_done;
  logic       sccb_nack;

  modport master (
    output sccb_valid, sccb_addr, sccb_data,
    input  sccb_ready, sccb_done, sccb_nack
  );

  modport slave (
    input  sccb_valid, sccb_addr, sccb_data,
    output sccb_ready, sccb_done, sccb_nack
  );
endinterface

// File: rtl/cam_config_seq.sv
// Walks a {reg_addr,reg_data} ROM and issues one SCCB write per entry, with inline
// delay/end markers and NACK retry. Request held until accepted; start ignored while busy.
module cam_config_seq #(
  parameter int ROM_AW       = 8,
  parameter int DELAY_CYCLES = 1250000,
  parameter int MAX_RETRY    = 3
) (
  input  logic              i_sysclk,
  input  logic              i_rstn,
  input  logic              i_cfg_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  cam_config_seq_if.master  sccb,
  output logic              o_busy,
  output logic              o_cfg_done,
  output logic              o_error
);

  localparam int CW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0]     DLY_LOAD  = CW'(DELAY_CYCLES - 1);
  localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [ROM_AW-1:0] LAST_ADDR = '1;
  localparam logic [15:0]       MARK_END  = 16'hFFFF;
  localparam logic [15:0]       MARK_DLY  = 16'hFFF0;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SEND, S_WAIT, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t            state_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic              valid_q;
  logic [7:0]        addr_q;
  logic [7:0]        data_q;
  logic              done_q;
  logic              error_q;
  logic [RW-1:0]     retry_q;
  logic [CW-1:0]     cnt_q;
  logic              advance;

  // Entry finished (acked write or expired delay): move to the next ROM word.
  always_comb begin
    advance = ((state_q == S_WAIT) && sccb.sccb_done && !sccb.sccb_nack) ||
              ((state_q == S_DELAY) && (cnt_q == '0));
  end

  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      retry_q    <= '0;
      cnt_q      <= '0;
    end else if (advance) begin
      retry_q <= '0;
      if (rom_addr_q == LAST_ADDR) begin
        state_q <= S_DONE;
        done_q  <= 1'b1;
      end else begin
        rom_addr_q <= rom_addr_q + ROM_AW'(1);
        state_q    <= S_FETCH;
      end
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_cfg_start) begin
            rom_addr_q <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            retry_q    <= '0;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          if (i_rom_data == MARK_END) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (i_rom_data == MARK_DLY) begin
            cnt_q   <= DLY_LOAD;
            state_q <= S_DELAY;
          end else begin
            addr_q  <= i_rom_data[15:8];
            data_q  <= i_rom_data[7:0];
            valid_q <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (sccb.sccb_ready) begin
            valid_q <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        // Only the NACK case reaches here; an ack is taken by advance.
        S_WAIT: begin
          if (sccb.sccb_done) begin
            if (retry_q < RETRY_MAX) begin
              retry_q <= retry_q + RW'(1);
              valid_q <= 1'b1;
              state_q <= S_SEND;
            end else begin
              error_q <= 1'b1;
              done_q  <= 1'b0;
              state_q <= S_ERROR;
            end
          end
        end
        S_DELAY: cnt_q <= cnt_q - CW'(1);
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_rom_addr      = rom_addr_q;
  assign sccb.sccb_valid = valid_q;
  assign sccb.sccb_addr  = addr_q;
  assign sccb.sccb_data  = data_q;
  assign o_cfg_done      = done_q;
  assign o_error         = error_q;
  assign o_busy          = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));

endmodule

// File: tb/tb_cam_config_seq.sv
// Bench for cam_config_seq: 4-entry ROM, 4-cycle delay marker, 2 retries; scoreboarded SCCB writes.
module tb_cam_config_seq;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  rom_addr;
  logic [15:0] rom_data;
  logic        busy, cfg_done, err;
  logic [15:0] rom [4];

  cam_config_seq_if sccb ();

  cam_config_seq #(.ROM_AW(2), .DELAY_CYCLES(4), .MAX_RETRY(2)) dut (
    .i_sysclk   (clk),
    .i_rstn     (rstn),
    .i_cfg_start(start),
    .o_rom_addr (rom_addr),
    .i_rom_data (rom_data),
    .sccb       (sccb),
    .o_busy     (busy),
    .o_cfg_done (cfg_done),
    .o_error    (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [15:0] exp_q[$];
  logic        nack_q[$];
  int          gap_q[$];
  int          write_cnt = 0;
  int          cyc = 0;
  int          last_done = 0;
  logic        valid_prev = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_exp(logic [15:0] w, int n);
    for (int i = 0; i < n; i++) exp_q.push_back(w);
  endtask

  // Monitor: scoreboard every accepted write; record done-to-next-request gaps.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (sccb.sccb_done) last_done = cyc;
      if (sccb.sccb_valid && !valid_prev) gap_q.push_back(cyc - last_done);
      valid_prev = sccb.sccb_valid;
      if (sccb.sccb_valid && sccb.sccb_ready) begin
        write_cnt++;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_write: got %h%h expected none", sccb.sccb_addr, sccb.sccb_data);
        end else begin
          check("sccb_write", {sccb.sccb_addr, sccb.sccb_data}, exp_q.pop_front());
        end
      end
    end
  end

  // SCCB slave: done pulse 2 cycles after accept, NACK taken from the script queue.
  initial begin
    sccb.sccb_done = 1'b0;
    sccb.sccb_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && sccb.sccb_valid && sccb.sccb_ready) begin
        @(posedge clk);
        @(posedge clk);
        #1;
        sccb.sccb_done = 1'b1;
        sccb.sccb_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        @(posedge clk);
        #1;
        sccb.sccb_done = 1'b0;
        sccb.sccb_nack = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_end(string name, int max);
    int n = 0;
    while (!(cfg_done || err) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!(cfg_done || err)) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_timeout: got no done/error expected one within %0d cycles", name, max);
    end
    @(negedge clk);
  endtask

  task automatic wait_valid(string name, int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sccb.sccb_valid && n < max);
    if (!sccb.sccb_valid) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_timeout: got no valid expected one within %0d cycles", name, max);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int n;
    logic seen3, wrapped;
    sccb.sccb_ready = 1'b0;
    rom = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", sccb.sccb_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", cfg_done, 0);
    check("rst_error", err, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_addr_data", {sccb.sccb_addr, sccb.sccb_data}, 0);
    @(posedge clk); #1 rstn = 1'b1;

    // Write, delay marker, write, end marker
    rom = '{16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF};
    sccb.sccb_ready = 1'b1;
    push_exp(16'h1280, 1);
    push_exp(16'h1101, 1);
    gap_q.delete();
    w0 = write_cnt;
    pulse_start();
    wait_end("t1", 200);
    check("t1_done", cfg_done, 1);
    check("t1_busy", busy, 0);
    check("t1_error", err, 0);
    check("t1_writes", write_cnt - w0, 2);
    check("t1_delay_gap", (gap_q.size() == 2) ? gap_q[1] : -1, 9);

    // Stalled request held stable, then back-to-back write
    rom = '{16'h3456, 16'h7890, 16'hFFFF, 16'hFFFF};
    sccb.sccb_ready = 1'b0;
    push_exp(16'h3456, 1);
    push_exp(16'h7890, 1);
    gap_q.delete();
    w0 = write_cnt;
    pulse_start();
    wait_valid("t2", 20);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold", {sccb.sccb_valid, sccb.sccb_addr, sccb.sccb_data}, {1'b1, 16'h3456});
      if (i < 4) @(negedge clk);
    end
    check("t2_no_early_xfer", write_cnt - w0, 0);
    @(posedge clk); #1 sccb.sccb_ready = 1'b1;
    wait_end("t2", 200);
    check("t2_writes", write_cnt - w0, 2);
    check("t2_b2b_gap", (gap_q.size() == 2) ? gap_q[1] : -1, 3);

    // Two NACKs then ACK
    rom = '{16'h2211, 16'h3322, 16'hFFFF, 16'hFFFF};
    nack_q = '{1'b1, 1'b1};
    push_exp(16'h2211, 3);
    push_exp(16'h3322, 1);
    w0 = write_cnt;
    pulse_start();
    wait_end("t3", 300);
    check("t3_done", cfg_done, 1);
    check("t3_error", err, 0);
    check("t3_writes", write_cnt - w0, 4);

    // NACK on every attempt
    rom = '{16'h5A5A, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    nack_q = '{1'b1, 1'b1, 1'b1};
    push_exp(16'h5A5A, 3);
    w0 = write_cnt;
    pulse_start();
    wait_end("t4", 300);
    check("t4_error", err, 1);
    check("t4_done", cfg_done, 0);
    check("t4_busy", busy, 0);
    check("t4_writes", write_cnt - w0, 3);

    // Start during WAIT is ignored
    rom = '{16'h6677, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    push_exp(16'h6677, 1);
    w0 = write_cnt;
    pulse_start();
    wait_valid("t5", 20);
    pulse_start();
    wait_end("t5", 200);
    check("t5_done", cfg_done, 1);
    check("t5_writes", write_cnt - w0, 1);
    check("t5_rom_addr", rom_addr, 1);

    // Start in DONE replays from address 0
    push_exp(16'h6677, 1);
    w0 = write_cnt;
    pulse_start();
    @(negedge clk);
    check("t6_done_drop", cfg_done, 0);
    check("t6_busy", busy, 1);
    check("t6_rom_addr", rom_addr, 0);
    wait_end("t6", 200);
    check("t6_done", cfg_done, 1);
    check("t6_writes", write_cnt - w0, 1);

    // Reset while a request is pending in SEND
    rom = '{16'h4455, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    sccb.sccb_ready = 1'b0;
    w0 = write_cnt;
    pulse_start();
    wait_valid("t7", 20);
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t7_valid", sccb.sccb_valid, 0);
    check("t7_addr_data", {sccb.sccb_addr, sccb.sccb_data}, 0);
    check("t7_status", {busy, cfg_done, err}, 0);
    check("t7_rom_addr", rom_addr, 0);
    @(posedge clk); #1 rstn = 1'b1;
    sccb.sccb_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("t7_idle_busy", busy, 0);
    check("t7_writes", write_cnt - w0, 0);

    // No end marker: run to the last address, no wrap
    rom = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
    push_exp(16'h0101, 1);
    push_exp(16'h0202, 1);
    push_exp(16'h0303, 1);
    push_exp(16'h0404, 1);
    w0 = write_cnt;
    pulse_start();
    n = 0;
    seen3 = 1'b0;
    wrapped = 1'b0;
    while (!cfg_done && n < 300) begin
      @(negedge clk);
      n++;
      if (rom_addr == 2'd3) seen3 = 1'b1;
      else if (seen3 && rom_addr == 2'd0) wrapped = 1'b1;
    end
    repeat (3) @(negedge clk);
    check("t8_done", cfg_done, 1);
    check("t8_writes", write_cnt - w0, 4);
    check("t8_rom_addr", rom_addr, 3);
    check("t8_no_wrap", wrapped, 0);
    check("exp_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
